// File: rtl/fbline_writer.sv
// Packs 8-bit colormap indices four per word and writes display lines to the
// framebuffer over pipelined Wishbone, one outstanding transaction at a time.
module fbline_writer #(
  parameter int ADDRESS_WIDTH  = 24,
  parameter int BUS_DATA_WIDTH = 32,
  parameter int FW             = 13,
  parameter int LW             = 12
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_en,
  input  logic [ADDRESS_WIDTH-1:0]  i_base_addr,
  input  logic [FW:0]               i_line_words,
  input  logic [LW-1:0]             i_vm_height,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [7:0]                i_pixel,
  input  logic                      i_last,
  output logic                      o_wb_cyc,
  output logic                      o_wb_stb,
  output logic                      o_wb_we,
  output logic [ADDRESS_WIDTH-1:0]  o_wb_addr,
  output logic [BUS_DATA_WIDTH-1:0] o_wb_data,
  output logic [3:0]                o_wb_sel,
  input  logic                      i_wb_stall,
  input  logic                      i_wb_ack,
  input  logic                      i_wb_err,
  output logic [LW-1:0]             o_line,
  output logic                      o_frame,
  output logic                      o_err
);
  localparam int AW = ADDRESS_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [1:0]                r_state;
  logic [31:0]               r_word;
  logic [1:0]                r_fill;
  logic [FW:0]               r_widx;
  logic [AW-1:0]             r_line_off;
  logic                      r_drop;
  logic                      r_last_pend;
  logic                      r_cyc, r_stb;
  logic [AW-1:0]             r_addr;
  logic [BUS_DATA_WIDTH-1:0] r_data;
  logic [LW-1:0]             r_line;
  logic                      r_frame, r_err;

  logic        w_accept, w_complete, w_inrange, w_bus_done, w_adv, w_wrap;
  logic [31:0] w_word;

  assign w_accept   = i_en && (r_state == S_IDLE) && i_valid;
  // Pixels land left-justified; unused low bytes stay zero for short words.
  assign w_word     = r_word | ({i_pixel, 24'h000000} >> {r_fill, 3'b000});
  assign w_complete = w_accept && ((r_fill == 2'd3) || i_last);
  assign w_inrange  = (r_widx < i_line_words) && !r_drop;
  assign w_wrap     = (r_line == i_vm_height - 1'b1);

  // A bus transaction ends on ack, or on err which takes precedence.
  assign w_bus_done = ((r_state == S_BUS) && (i_wb_err || (!i_wb_stall && i_wb_ack))) ||
                      ((r_state == S_ACK) && (i_wb_err || i_wb_ack));
  assign w_adv      = (w_complete && i_last && !w_inrange) ||
                      (w_bus_done && r_last_pend);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_word      <= '0;
      r_fill      <= '0;
      r_widx      <= '0;
      r_line_off  <= '0;
      r_drop      <= 1'b0;
      r_last_pend <= 1'b0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_line      <= '0;
      r_frame     <= 1'b0;
      r_err       <= 1'b0;
    end else if (!i_en) begin
      r_state     <= S_IDLE;
      r_word      <= '0;
      r_fill      <= '0;
      r_widx      <= '0;
      r_line_off  <= '0;
      r_drop      <= 1'b0;
      r_last_pend <= 1'b0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_line      <= '0;
      r_frame     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_frame <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_complete) begin
            r_word <= '0;
            r_fill <= '0;
            if (r_widx != '1) r_widx <= r_widx + 1'b1;
            if (w_inrange) begin
              r_state     <= S_BUS;
              r_cyc       <= 1'b1;
              r_stb       <= 1'b1;
              r_addr      <= i_base_addr + r_line_off + AW'(r_widx);
              r_data      <= BUS_DATA_WIDTH'(w_word);
              r_last_pend <= i_last;
            end
          end else if (w_accept) begin
            r_word <= w_word;
            r_fill <= r_fill + 1'b1;
          end
        end
        S_BUS: begin
          if (i_wb_err) begin
            r_state <= S_IDLE;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_err   <= 1'b1;
            r_drop  <= 1'b1;
          end else if (!i_wb_stall) begin
            r_stb <= 1'b0;
            if (i_wb_ack) begin
              r_state <= S_IDLE;
              r_cyc   <= 1'b0;
            end else begin
              r_state <= S_ACK;
            end
          end
        end
        S_ACK: begin
          if (i_wb_err) begin
            r_state <= S_IDLE;
            r_cyc   <= 1'b0;
            r_err   <= 1'b1;
            r_drop  <= 1'b1;
          end else if (i_wb_ack) begin
            r_state <= S_IDLE;
            r_cyc   <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cyc   <= 1'b0;
          r_stb   <= 1'b0;
        end
      endcase

      // Line advance overrides the per-word index update above.
      if (w_adv) begin
        r_widx      <= '0;
        r_drop      <= 1'b0;
        r_last_pend <= 1'b0;
        if (w_wrap) begin
          r_line     <= '0;
          r_line_off <= '0;
          r_frame    <= 1'b1;
        end else begin
          r_line     <= r_line + 1'b1;
          r_line_off <= r_line_off + AW'(i_line_words);
        end
      end
    end
  end

  assign o_ready   = !i_en || (r_state == S_IDLE);
  assign o_wb_cyc  = r_cyc;
  assign o_wb_stb  = r_stb;
  assign o_wb_we   = r_cyc;
  assign o_wb_addr = r_addr;
  assign o_wb_data = r_data;
  assign o_wb_sel  = 4'hf;
  assign o_line    = r_line;
  assign o_frame   = r_frame;
  assign o_err     = r_err;
endmodule

// File: tb/tb_fbline_writer.sv
// Bench for fbline_writer: a line-level model predicts every bus write, a
// negedge monitor compares each accepted strobe, plus literal spot checks.
module tb_fbline_writer;
  localparam int AW = 24;
  localparam int FW = 13;
  localparam int LW = 12;

  logic          i_clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_en = 1'b0;
  logic [AW-1:0] i_base_addr = 24'h000100;
  logic [FW:0]   i_line_words = 14'd2;
  logic [LW-1:0] i_vm_height = 12'd4;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [7:0]    i_pixel = 8'h00;
  logic          i_last = 1'b0;
  logic          o_wb_cyc, o_wb_stb, o_wb_we;
  logic [AW-1:0] o_wb_addr;
  logic [31:0]   o_wb_data;
  logic [3:0]    o_wb_sel;
  logic          i_wb_stall = 1'b0;
  logic          i_wb_ack, i_wb_err;
  logic [LW-1:0] o_line;
  logic          o_frame, o_err;

  always #5 i_clk = ~i_clk;

  fbline_writer #(.ADDRESS_WIDTH(AW), .BUS_DATA_WIDTH(32), .FW(FW), .LW(LW)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_en(i_en),
    .i_base_addr(i_base_addr), .i_line_words(i_line_words), .i_vm_height(i_vm_height),
    .i_valid(i_valid), .o_ready(o_ready), .i_pixel(i_pixel), .i_last(i_last),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
    .o_line(o_line), .o_frame(o_frame), .o_err(o_err)
  );

  // Wishbone slave: immediate ack, optional one-cycle-late ack, one-shot error.
  logic late_ack = 1'b0;
  logic err_once = 1'b0;
  logic ack_d = 1'b0;
  logic w_acc;
  assign w_acc    = o_wb_cyc & o_wb_stb & ~i_wb_stall;
  assign i_wb_ack = late_ack ? ack_d : (w_acc & ~err_once);
  assign i_wb_err = w_acc & err_once;
  always @(posedge i_clk) ack_d <= late_ack & w_acc & ~err_once;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Line-level model: which words of a line reach the bus and where.
  logic [55:0] expq[$];
  logic [55:0] logq[$];
  int m_line = 0, m_off = 0, m_frames = 0;

  task automatic model_line(input int n, input logic [7:0] first, input int lw,
                            input int h, input int base, input bit err_first);
    int nw;
    logic [31:0] d;
    nw = (n + 3) / 4;
    for (int k = 0; k < nw; k++) begin
      if (k < lw && !(err_first && k > 0)) begin
        d = 32'h0;
        for (int b = 0; b < 4; b++)
          if (4 * k + b < n) d[31 - 8 * b -: 8] = first + 8'(4 * k + b);
        expq.push_back({24'(base + m_off + k), d});
      end
    end
    if (m_line == h - 1) begin
      m_line = 0; m_off = 0; m_frames++;
    end else begin
      m_line++; m_off += lw;
    end
  endtask

  // Monitor: every accepted strobe must match the next modelled write.
  int frames_seen = 0;
  int stall_seen = 0;
  logic prev_st = 1'b0;
  logic [55:0] prev_ad = '0;
  logic [55:0] pop_v;
  always @(negedge i_clk) begin
    if (i_reset_n) begin
      if (o_frame) frames_seen++;
      if (w_acc) begin
        logq.push_back({o_wb_addr, o_wb_data});
        chk("sel_we", 64'({o_wb_sel, o_wb_we}), 64'h1f);
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr %h data %h, expected none", o_wb_addr, o_wb_data);
        end else begin
          pop_v = expq.pop_front();
          chk("write", 64'({o_wb_addr, o_wb_data}), 64'(pop_v));
        end
      end
      if (o_wb_cyc && o_wb_stb && i_wb_stall) begin
        stall_seen++;
        chk("stall_ready", 64'(o_ready), 64'h0);
        if (prev_st) chk("stall_hold", 64'({o_wb_addr, o_wb_data}), 64'(prev_ad));
      end
      prev_st = o_wb_cyc && o_wb_stb && i_wb_stall;
      prev_ad = {o_wb_addr, o_wb_data};
    end
  end

  task automatic send_line(input int n, input logic [7:0] first);
    int t;
    logic r;
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk);
      i_valid = 1'b1; i_pixel = first + 8'(i); i_last = (i == n - 1);
      r = o_ready; t = 0;
      while (!r && t < 100) begin
        @(negedge i_clk); r = o_ready; t++;
      end
      if (!r) begin
        checks++; errors++;
        $display("FAIL ready_timeout: got o_ready=0 for 100 cycles, expected 1");
      end
      @(posedge i_clk);
    end
    @(negedge i_clk);
    i_valid = 1'b0; i_last = 1'b0;
    t = 0;
    while (o_wb_cyc && t < 50) begin
      @(negedge i_clk); t++;
    end
    if (o_wb_cyc) begin
      checks++; errors++;
      $display("FAIL bus_timeout: got cyc=1 for 50 cycles, expected 0");
    end
    repeat (2) @(negedge i_clk);
  endtask

  task automatic wait_stb();
    int t;
    t = 0;
    while (!(o_wb_cyc && o_wb_stb) && t < 100) begin
      @(negedge i_clk); t++;
    end
  endtask

  initial begin
    #2;
    chk("rst_bus", 64'({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data}), 64'h0);
    chk("rst_status", 64'({o_line, o_frame, o_err}), 64'h0);
    chk("rst_ready_sel", 64'({o_ready, o_wb_sel}), 64'h1f);
    #10;
    i_reset_n = 1'b1; i_en = 1'b1;

    // Line 0: exact two words, i_last on the 4th pixel of the second.
    model_line(8, 8'h01, 2, 4, 'h100, 0);
    send_line(8, 8'h01);
    chk("t1_w0", 64'(logq[0]), 64'h0000_0100_0102_0304);
    chk("t1_w1", 64'(logq[1]), 64'h0000_0101_0506_0708);
    chk("t1_line", 64'(o_line), 64'd1);

    // Line 1: partial last word is zero padded.
    model_line(6, 8'hA0, 2, 4, 'h100, 0);
    send_line(6, 8'hA0);
    chk("t2_w0", 64'(logq[2]), 64'h0000_0102_A0A1_A2A3);
    chk("t2_w1", 64'(logq[3]), 64'h0000_0103_A4A5_0000);

    // Line 2: slave stalls the first word for three cycles.
    model_line(8, 8'h10, 2, 4, 'h100, 0);
    i_wb_stall = 1'b1;
    fork
      send_line(8, 8'h10);
      begin
        wait_stb();
        repeat (3) @(posedge i_clk);
        #1 i_wb_stall = 1'b0;
      end
    join
    chk("t3_stall_cycles", 64'(stall_seen), 64'd3);
    chk("t3_w0", 64'(logq[4]), 64'h0000_0104_1011_1213);
    chk("t3_line", 64'(o_line), 64'd3);

    // Line 3: 12 pixels but only 2 words allowed; last line wraps the frame.
    model_line(12, 8'h20, 2, 4, 'h100, 0);
    send_line(12, 8'h20);
    chk("t4_nwrites", 64'(logq.size()), 64'd8);
    chk("t4_frame", 64'(frames_seen), 64'd1);
    chk("t4_line", 64'(o_line), 64'd0);

    // Next frame restarts at the base, with a late ack exercising ACK.
    late_ack = 1'b1;
    model_line(4, 8'h30, 2, 4, 'h100, 0);
    send_line(4, 8'h30);
    late_ack = 1'b0;
    chk("t5_w0", 64'(logq[8]), 64'h0000_0100_3031_3233);
    chk("t5_line", 64'(o_line), 64'd1);

    // Disable rewinds to line 0; switch to 3-word lines.
    @(negedge i_clk); i_en = 1'b0; i_line_words = 14'd3;
    repeat (2) @(negedge i_clk);
    chk("dis_line", 64'(o_line), 64'd0);
    i_en = 1'b1; m_line = 0; m_off = 0;

    // Bus error on the first word suppresses the rest of that line.
    model_line(12, 8'h40, 3, 4, 'h100, 1);
    err_once = 1'b1;
    fork
      send_line(12, 8'h40);
      begin
        wait_stb();
        @(posedge i_clk);
        #1 err_once = 1'b0;
      end
    join
    chk("t6_err", 64'(o_err), 64'd1);
    chk("t6_nwrites", 64'(logq.size()), 64'd10);
    chk("t6_line", 64'(o_line), 64'd1);

    model_line(12, 8'h50, 3, 4, 'h100, 0);
    send_line(12, 8'h50);
    chk("t7_w2", 64'(logq[12]), 64'h0000_0105_585_9_5A5B);
    chk("t7_err_sticky", 64'(o_err), 64'd1);

    @(negedge i_clk); i_en = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("t7_err_clr", 64'(o_err), 64'd0);

    chk("end_expq_empty", 64'(expq.size()), 64'd0);
    chk("end_frames_model", 64'(frames_seen), 64'(m_frames));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by 200000, expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fbline_writer.md
# fbline_writer

Upstream framebuffer producer for the spectrogram display. Accepts a stream of 8-bit colormap indices, one display line at a time, packs four per 32-bit word (first pixel in bits [31:24]) and writes each word to framebuffer memory over pipelined Wishbone. Lines are placed at `i_base_addr + line*i_line_words` and wrap at the frame height. This produces exactly the layout the HDMI frame reader fetches and unpacks.

## Interface
- `ADDRESS_WIDTH` (`AW`), 24: Wishbone word-address width.
- `BUS_DATA_WIDTH` (`DW`), 32: bus width; fixed at 32, four 8-bit pixels per word.
- `FW`, 13: horizontal count width; `i_line_words` is FW+1 bits.
- `LW`, 12: line counter width.

Ports:
- `i_clk` in 1: single clock; all logic on its rising edge.
- `i_reset_n` in 1: asynchronous, active-low reset.
- `i_en` in 1: enable; low aborts and rewinds to line 0.
- `i_base_addr` in AW: framebuffer word address of line 0.
- `i_line_words` in FW+1: words per line (stride and per-line write limit).
- `i_vm_height` in LW: lines per frame.
- `i_valid` in 1: pixel valid.
- `o_ready` out 1: pixel accepted when `i_valid && o_ready`.
- `i_pixel` in 8: colormap index.
- `i_last` in 1: qualifies the final pixel of a line.
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we` out 1 each: Wishbone master; `we` = `cyc`.
- `o_wb_addr` out AW: Wishbone word address.
- `o_wb_data` out 32: Wishbone write data.
- `o_wb_sel` out 4: Wishbone byte selects; always 4'hf.
- `i_wb_stall`, `i_wb_ack`, `i_wb_err` in 1 each: Wishbone slave responses.
- `o_line` out LW: line currently being written.
- `o_frame` out 1: one-cycle pulse on frame wrap.
- `o_err` out 1: sticky bus-error flag.

## Operation
- States:
  - IDLE: `cyc`=0, `o_ready`=1.
  - BUS: `cyc`=`stb`=1, `o_ready`=0.
  - ACK: `cyc`=1, `stb`=0, `o_ready`=0.
- IDLE: each accepted pixel shifts into the word register and increments `fill` (0..3).
  - A word completes on the 4th pixel, or on `i_last` with fewer pixels.
  - A partial word is left-justified with zero padding (e.g. 2 pixels `A`,`B` give `{A,B,8'h00,8'h00}`), written with full `sel`.
- Word index `widx` (FW+1 bits) counts words within the line.
  - `widx < i_line_words`: go to BUS with `o_wb_addr = line_addr + widx`.
  - `widx >= i_line_words`: the write is suppressed. The word is dropped, the state stays IDLE and `o_ready` stays 1.
- BUS: drop `stb` once `!i_wb_stall`. Enter ACK, or go straight to IDLE if `i_wb_ack` arrives in the same cycle. At most one transaction is outstanding.
- ACK: on `i_wb_ack`, drop `cyc` and return to IDLE.
- Line completion:
  - The line advances after the last word of a line has been written, or immediately if that word was suppressed.
  - Advance sets `widx`=0 and `line_addr += i_line_words`.
  - If `o_line == i_vm_height-1`: set `o_line`=0, `line_addr`=`i_base_addr`, and pulse `o_frame`.
- Address arithmetic is AW bits and wraps modulo 2^AW without flagging.
- Bus error (`i_wb_err` in BUS or ACK):
  - Drop `cyc`/`stb` the next cycle and set `o_err`.
  - Return to IDLE and suppress all remaining writes of the current line.
  - Continue consuming pixels; the line advances normally at `i_last`.
- `i_en` low:
  - Clear `cyc`/`stb` next cycle, abandoning any transaction.
  - Clear `fill`, `widx` and `o_line`; load `line_addr` with `i_base_addr`.
  - Clear `o_err`.
  - `o_ready`=1; pixels are discarded.

## Timing
- Reset (asynchronous, any cycle): state IDLE, `o_ready`=1, and all of these cleared to 0:
  - `o_wb_cyc`, `o_wb_stb`, `o_wb_we`, `o_wb_addr`, `o_wb_data`
  - `o_line`, `o_frame`, `o_err`
- `o_wb_sel` = 4'hf at all times.
- `o_wb_stb` rises the cycle after the completing pixel is accepted. Address and data are stable while `stb` and `stall` are both high.
- Best-case cost per word: 4 pixel cycles, 1 BUS cycle (ack in same cycle), 0 ACK cycles, i.e. 5 cycles.
- `o_frame` asserts the cycle after the final write of the last line completes, for exactly 1 cycle.
- `i_last` on the 4th pixel of a word ends the line with that one write; no extra empty word is produced.
- An `i_wb_ack` arriving in IDLE is ignored.
- If `i_wb_err` and `i_wb_ack` arrive together, error handling takes precedence.

## Test plan
- Stream 8 pixels 0x01..0x08 with `i_last` on 0x08; base=0x100, line_words=2, height=4, no stall. Expect two writes: 0x100 with 0x01020304, then 0x101 with 0x05060708. Then `o_line`=1.
- Stream a 6-pixel line 0xA0..0xA5 with `i_last`. Expect 0xA0A1A2A3, then 0xA4A50000.
- Hold stall high for 3 cycles on the first word. Expect `stb`, `addr` and `data` held for 3 cycles and `o_ready`=0 throughout; the write completes on the first cycle `stall` is low.
- Line of 12 pixels with line_words=2. Expect only 2 writes; pixels 9–12 are accepted with no bus activity, then the line advances.
- Write 4 lines, height=4. Expect line start addresses 0x100, 0x102, 0x104, 0x106, then a 1-cycle `o_frame` pulse and the next line written at 0x100.
- Assert `i_wb_err` on the first word of a 3-word line. Expect `o_err`=1 and no further writes that line; the next line writes normally; dropping `i_en` clears `o_err`.
